rf_wr_arbiter: RTL

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

---
 rtl/rf_wr_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter between ALU and load-unit writebacks.
// LSU is favoured unless the ALU has stalled STARVE_LIMIT consecutive cycles.
package my_pkg;
    parameter int DATA_WIDTH = 32;
endpackage

module rf_wr_arbiter #(
    parameter int DATA_WIDTH   = my_pkg::DATA_WIDTH,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [4:0]            lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    output logic                  rf_wr_en,
    output logic [4:0]            rf_addr_wr,
    output logic [DATA_WIDTH-1:0] rf_data_wr,
    output logic                  alu_prio
);

    typedef enum logic {
        PRIO_LSU = 1'b0,
        PRIO_ALU = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_alu_xfer;
    logic                  w_lsu_xfer;
    logic [4:0]            w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PRIO_LSU;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_alu_xfer = alu_valid & alu_ready;
    assign w_lsu_xfer = lsu_valid & lsu_ready;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!alu_valid || w_alu_xfer)
            w_cnt_nxt = 4'd0;
        else if (r_cnt != 4'hF)
            w_cnt_nxt = r_cnt + 4'd1;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            PRIO_LSU: begin
                if (w_cnt_nxt == 4'(STARVE_LIMIT))
                    w_state_nxt = PRIO_ALU;
            end
            PRIO_ALU: begin
                if (w_alu_xfer || !alu_valid)
                    w_state_nxt = PRIO_LSU;
            end
            default: w_state_nxt = PRIO_LSU;
        endcase
    end

    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        unique case (r_state)
            PRIO_LSU: begin
                lsu_ready = lsu_valid;
                alu_ready = alu_valid & ~lsu_valid;
            end
            PRIO_ALU: begin
                alu_ready = alu_valid;
                lsu_ready = lsu_valid & ~alu_valid;
            end
            default: begin
                alu_ready = 1'b0;
                lsu_ready = 1'b0;
            end
        endcase
    end

    assign alu_prio = (r_state == PRIO_ALU);

    // Writes to x0 are accepted but dropped here.
    assign w_sel_rd   = w_alu_xfer ? alu_rd : lsu_rd;
    assign w_sel_data = w_alu_xfer ? alu_data : lsu_data;
    assign w_wr       = (w_alu_xfer | w_lsu_xfer) & (w_sel_rd != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en   <= 1'b0;
            rf_addr_wr <= 5'd0;
            rf_data_wr <= '0;
        end else begin
            rf_wr_en <= w_wr;
            if (w_wr) begin
                rf_addr_wr <= w_sel_rd;
                rf_data_wr <= w_sel_data;
            end
        end
    end

endmodule
